// File: rtl/mux3_bus_arbiter.sv
// Round-robin arbiter owning the select/grant of a 3-input 8-bit result-bus mux; ARB_BURST_LIMIT_EN adds burst preemption.
// Latency: grant/sel/busy/own_cnt registered, one edge after req is sampled; handoff between owners has no dead cycle.
// Backpressure: none beyond level req; a requester holds req until granted and keeps the bus until it drops req.
module mux3_bus_arbiter #(
  parameter int CNT_W     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [2:0]       req,
  output logic [2:0]       grant,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] own_cnt
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  logic [1:0] last_owner;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First set bit of r scanning upward from 'from' with wrap-around.
  function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [2:0] r);
    logic [3:0] rx;
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    rx    = {1'b0, r};
    idx   = (from == 2'd3) ? 2'd0 : from;
    pick  = idx;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && rx[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = inc3(idx);
    end
    return pick;
  endfunction

  logic [3:0]       req_x;
  logic [2:0]       others;
  logic [1:0]       idle_pick;
  logic [1:0]       hand_pick;
  logic             own_req;
  logic             state_ok;
  logic             preempt;
  logic [CNT_W-1:0] cnt_inc;

  assign req_x     = {1'b0, req};
  assign others    = req & ~grant;
  assign own_req   = req_x[sel];
  assign idle_pick = rr_pick(inc3(last_owner), req);
  assign hand_pick = rr_pick(inc3(sel), others);
  assign cnt_inc   = (own_cnt == {CNT_W{1'b1}}) ? own_cnt : own_cnt + CNT_ONE;

  // Registered outputs double as the owner index, so cross-check them against the state.
  assign state_ok = (state == IDLE) ? (grant == 3'b000 && sel == 2'b11)
                                    : (sel != 2'b11 && grant == (3'b001 << sel));

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);
  assign preempt = (own_cnt == BURST_CAP) && (|others);
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 3'b000;
      sel        <= 2'b11;
      busy       <= 1'b0;
      own_cnt    <= '0;
      last_owner <= 2'd2;
    end else if (!state_ok) begin
      state   <= IDLE;
      grant   <= 3'b000;
      sel     <= 2'b11;
      busy    <= 1'b0;
      own_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= OWN;
            grant   <= 3'b001 << idle_pick;
            sel     <= idle_pick;
            busy    <= 1'b1;
            own_cnt <= CNT_ONE;
          end
        end
        OWN: begin
          if (!own_req || preempt) begin
            last_owner <= sel;
            if (|others) begin
              grant   <= 3'b001 << hand_pick;
              sel     <= hand_pick;
              own_cnt <= CNT_ONE;
            end else begin
              state   <= IDLE;
              grant   <= 3'b000;
              sel     <= 2'b11;
              busy    <= 1'b0;
              own_cnt <= '0;
            end
          end else begin
            own_cnt <= cnt_inc;
          end
        end
        default: begin
          state   <= IDLE;
          grant   <= 3'b000;
          sel     <= 2'b11;
          busy    <= 1'b0;
          own_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// Scoreboard bench for mux3_bus_arbiter: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_mux3_bus_arbiter;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] req    = 3'b000;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] own_cnt;

  mux3_bus_arbiter #(.CNT_W(8), .MAX_BURST(4)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .own_cnt (own_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] g;
    logic [1:0] s;
    logic       b;
    logic [7:0] c;
    string      name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Apply inputs for the next edge and queue the outputs expected right after it.
  task automatic step(input logic [2:0] r, input logic rn, input logic [2:0] g,
                      input logic [1:0] s, input int c, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    req    = r;
    resetn = rn;
    e.cyc  = cyc + 1;
    e.g    = g;
    e.s    = s;
    e.b    = (g != 3'b000);
    e.c    = c[7:0];
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL %s: sample missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        tests++;
        if (grant !== e.g || sel !== e.s || busy !== e.b || own_cnt !== e.c) begin
          fails++;
          $display("FAIL %s: got grant=%b sel=%b busy=%b own_cnt=%0d, expected grant=%b sel=%b busy=%b own_cnt=%0d",
                   e.name, grant, sel, busy, own_cnt, e.g, e.s, e.b, e.c);
        end
      end
      tests++;
      if (((sel == 2'b11) != (grant == 3'b000)) || !$onehot0(grant) || (busy != (grant != 3'b000))) begin
        fails++;
        $display("FAIL invariant at cycle %0d: grant=%b sel=%b busy=%b", cyc, grant, sel, busy);
      end
    end
  end

  initial begin
    // Reset held with all requests up, then release.
    step(3'b111, 1'b0, 3'b000, 2'b11, 0, "rst_hold0");
    step(3'b111, 1'b0, 3'b000, 2'b11, 0, "rst_hold1");
    step(3'b111, 1'b1, 3'b001, 2'b00, 1, "rst_release");
    step(3'b111, 1'b1, 3'b001, 2'b00, 2, "rr_own0_c2");
    // Round robin: each owner drops req for one edge at own_cnt=2.
    step(3'b110, 1'b1, 3'b010, 2'b01, 1, "rr_0to1");
    step(3'b111, 1'b1, 3'b010, 2'b01, 2, "rr_own1_c2");
    step(3'b101, 1'b1, 3'b100, 2'b10, 1, "rr_1to2");
    step(3'b111, 1'b1, 3'b100, 2'b10, 2, "rr_own2_c2");
    step(3'b011, 1'b1, 3'b001, 2'b00, 1, "rr_2to0");
    // Direct handoff from owner 1 with 0 and 2 waiting: 2 wins.
    step(3'b010, 1'b1, 3'b010, 2'b01, 1, "to_owner1");
    step(3'b101, 1'b1, 3'b100, 2'b10, 1, "handoff_1to2");
    step(3'b000, 1'b1, 3'b000, 2'b11, 0, "go_idle");
    // Single requester 2, held 5 cycles then dropped.
    step(3'b100, 1'b1, 3'b100, 2'b10, 1, "single_grant");
    for (int k = 2; k <= 5; k++) step(3'b100, 1'b1, 3'b100, 2'b10, k, "single_hold");
    step(3'b000, 1'b1, 3'b000, 2'b11, 0, "single_drop");
    // Mid-burst reset at own_cnt=7.
    step(3'b100, 1'b1, 3'b100, 2'b10, 1, "burst_grant");
    for (int k = 2; k <= 7; k++) step(3'b100, 1'b1, 3'b100, 2'b10, k, "burst_hold");
    step(3'b110, 1'b0, 3'b000, 2'b11, 0, "midburst_rst");
    step(3'b110, 1'b1, 3'b010, 2'b01, 1, "post_rst_grant");
    // From idle after owner 1, scan starts at 2 and wraps to 0.
    step(3'b000, 1'b1, 3'b000, 2'b11, 0, "idle_after1");
    step(3'b011, 1'b1, 3'b001, 2'b00, 1, "idle_wrap");
    // Owner req pulses low between edges: no effect.
    step(3'b010, 1'b1, 3'b001, 2'b00, 2, "glitch_invisible");
    #2 req = 3'b011;
    // Counter saturation at 255 with a lone owner.
    for (int k = 3; k <= 258; k++) step(3'b001, 1'b1, 3'b001, 2'b00, (k > 255) ? 255 : k, "saturate");
    step(3'b000, 1'b1, 3'b000, 2'b11, 0, "sat_drop");
`ifdef ARB_BURST_LIMIT_EN
    step(3'b011, 1'b0, 3'b000, 2'b11, 0, "bl_rst");
    step(3'b011, 1'b1, 3'b001, 2'b00, 1, "bl_own0");
    for (int k = 2; k <= 4; k++) step(3'b011, 1'b1, 3'b001, 2'b00, k, "bl_own0_hold");
    for (int k = 1; k <= 4; k++) step(3'b011, 1'b1, 3'b010, 2'b01, k, "bl_preempt_to1");
    step(3'b011, 1'b1, 3'b001, 2'b00, 1, "bl_preempt_to0");
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
